// File: rtl/rv_pkg.sv
// Shared definitions for the RISC5 write-back slice.
//   REG_W / RNO_W    : register data width and register-number width
//   SRC_*            : 2-bit result-source codes carried on reg_writeback.src
//   wb_state_t       : write-back sequencer states
package rv_pkg;

    localparam int unsigned REG_W = 32;
    localparam int unsigned RNO_W = 4;

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_MUL  = 2'd1;
    localparam logic [1:0] SRC_DIV  = 2'd2;
    localparam logic [1:0] SRC_LOAD = 2'd3;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WAIT_MUL,
        WB_WAIT_DIV,
        WB_WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/reg_writeback.sv
// Write-back stage in front of the register file's synchronous write port.
// Accepts one operation per issue, waits for the selected result source and
// emits one registered write. Owns the H register (MUL high word / DIV remainder).
//   clk, rst_n         : clock, asynchronous active-low reset
//   issue, src, dst    : new operation strobe, result source, destination register
//   alu_res            : ALU result, valid with issue
//   mul_done/lo/hi     : multiplier result pulse and product words
//   div_done/q/r       : divider result pulse, quotient and remainder
//   ld_ack, ld_data    : load data pulse and data
//   wr, rno, din       : registered register-file write port
//   h                  : H register
//   stall              : high while waiting on a multi-cycle source
//   ld_timeout         : one-cycle pulse when a load is abandoned
module reg_writeback
    import rv_pkg::*;
#(
    parameter int unsigned LOAD_TO = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [1:0]       src,
    input  logic [RNO_W-1:0] dst,
    input  logic [REG_W-1:0] alu_res,
    input  logic             mul_done,
    input  logic [REG_W-1:0] mul_lo,
    input  logic [REG_W-1:0] mul_hi,
    input  logic             div_done,
    input  logic [REG_W-1:0] div_q,
    input  logic [REG_W-1:0] div_r,
    input  logic             ld_ack,
    input  logic [REG_W-1:0] ld_data,
    output logic             wr,
    output logic [RNO_W-1:0] rno,
    output logic [REG_W-1:0] din,
    output logic [REG_W-1:0] h,
    output logic             stall,
    output logic             ld_timeout
);

    wb_state_t        state_q, state_d;
    logic             wr_q, wr_d;
    logic [RNO_W-1:0] rno_q, rno_d;
    logic [REG_W-1:0] din_q, din_d;
    logic [REG_W-1:0] h_q, h_d;
    logic             to_q, to_d;
    logic [RNO_W-1:0] dst_q, dst_d;
    logic             ld_expire;

    generate
        if (LOAD_TO != 0) begin : g_timer
            localparam int unsigned TW = $clog2(LOAD_TO + 1);
            logic [TW-1:0] timer_q;

            // Held at zero outside WAIT_LOAD so every entry starts from zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    timer_q <= '0;
                end else if (state_q == WB_WAIT_LOAD) begin
                    timer_q <= timer_q + 1'b1;
                end else begin
                    timer_q <= '0;
                end
            end

            assign ld_expire = (state_q == WB_WAIT_LOAD) && (timer_q == TW'(LOAD_TO - 1));
        end else begin : g_no_timer
            assign ld_expire = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        wr_d    = 1'b0;
        rno_d   = rno_q;
        din_d   = din_q;
        h_d     = h_q;
        to_d    = 1'b0;
        dst_d   = dst_q;

        unique case (state_q)
            WB_IDLE: begin
                if (issue) begin
                    dst_d = dst;
                    unique case (src)
                        SRC_ALU: begin
                            wr_d  = 1'b1;
                            rno_d = dst;
                            din_d = alu_res;
                        end
                        SRC_MUL: begin
                            if (mul_done) begin
                                wr_d  = 1'b1;
                                rno_d = dst;
                                din_d = mul_lo;
                                h_d   = mul_hi;
                            end else begin
                                state_d = WB_WAIT_MUL;
                            end
                        end
                        SRC_DIV: begin
                            if (div_done) begin
                                wr_d  = 1'b1;
                                rno_d = dst;
                                din_d = div_q;
                                h_d   = div_r;
                            end else begin
                                state_d = WB_WAIT_DIV;
                            end
                        end
                        default: begin
                            if (ld_ack) begin
                                wr_d  = 1'b1;
                                rno_d = dst;
                                din_d = ld_data;
                            end else begin
                                state_d = WB_WAIT_LOAD;
                            end
                        end
                    endcase
                end
            end
            WB_WAIT_MUL: begin
                if (mul_done) begin
                    wr_d    = 1'b1;
                    rno_d   = dst_q;
                    din_d   = mul_lo;
                    h_d     = mul_hi;
                    state_d = WB_IDLE;
                end
            end
            WB_WAIT_DIV: begin
                if (div_done) begin
                    wr_d    = 1'b1;
                    rno_d   = dst_q;
                    din_d   = div_q;
                    h_d     = div_r;
                    state_d = WB_IDLE;
                end
            end
            default: begin
                // A late ack in the expiring cycle still completes the load.
                if (ld_ack) begin
                    wr_d    = 1'b1;
                    rno_d   = dst_q;
                    din_d   = ld_data;
                    state_d = WB_IDLE;
                end else if (ld_expire) begin
                    to_d    = 1'b1;
                    state_d = WB_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WB_IDLE;
            wr_q    <= 1'b0;
            rno_q   <= '0;
            din_q   <= '0;
            h_q     <= '0;
            to_q    <= 1'b0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rno_q   <= rno_d;
            din_q   <= din_d;
            h_q     <= h_d;
            to_q    <= to_d;
            dst_q   <= dst_d;
        end
    end

    assign wr         = wr_q;
    assign rno        = rno_q;
    assign din        = din_q;
    assign h          = h_q;
    assign ld_timeout = to_q;
    assign stall      = (state_q != WB_IDLE);

endmodule
